// File: rtl/rice_encoder.sv
// Serial Rice/Golomb encoder: unary quotient, stop bit and k-bit remainder,
// with an escape to raw sample bits once the quotient reaches QMAX.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// UNARY | emitting quotient ones (q of them, or QMAX on escape)
// STOP  | emitting the terminating zero
// REM   | emitting the k remainder bits, MSB first
// RAW   | emitting all DATA_W sample bits after an escape, MSB first
module rice_encoder #(
    parameter int DATA_W = 16,
    parameter int K_W    = 4,
    parameter int QMAX   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [K_W-1:0]    in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic              busy
);

    localparam int CNT_MAX = (QMAX > DATA_W) ? QMAX : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UNARY = 3'd1,
        STOP  = 3'd2,
        REM   = 3'd3,
        RAW   = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  x_reg;
    logic [DATA_W-1:0]  q_reg;
    logic [K_W-1:0]     k_reg;
    logic [DATA_W-1:0]  sh;
    logic [CNT_W-1:0]   cnt;

    logic [DATA_W-1:0]  q_in;
    logic               esc_in;
    logic               esc;
    logic               accept;
    logic               hs;
    logic [K_W:0]       rem_sh;

    assign q_in   = in_data >> in_k;
    assign esc_in = (q_in >= DATA_W'(QMAX));
    assign esc    = (q_reg >= DATA_W'(QMAX));
    assign accept = in_valid && in_ready;
    assign hs     = out_valid && out_ready;
    // left-justify the remainder so REM shares the MSB-first shifter with RAW
    assign rem_sh = (K_W+1)'(DATA_W) - {1'b0, k_reg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = reset;
                if (accept) begin
                    state_n = (q_in == '0) ? STOP : UNARY;
                end
            end
            UNARY: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = 1'b1;
                if (hs && cnt == '0) begin
                    state_n = esc ? RAW : STOP;
                end
            end
            STOP: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = 1'b0;
                out_last  = (k_reg == '0);
                if (hs) begin
                    state_n = (k_reg != '0) ? REM : IDLE;
                end
            end
            REM, RAW: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = sh[DATA_W-1];
                out_last  = (cnt == '0);
                if (hs && cnt == '0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg <= '0;
            q_reg <= '0;
            k_reg <= '0;
            sh    <= '0;
            cnt   <= '0;
        end else if (accept) begin
            x_reg <= in_data;
            q_reg <= q_in;
            k_reg <= in_k;
            sh    <= in_data;
            if (esc_in) begin
                cnt <= CNT_W'(QMAX - 1);
            end else if (q_in == '0) begin
                cnt <= '0;
            end else begin
                cnt <= CNT_W'(q_in - 1'b1);
            end
        end else if (hs) begin
            case (state)
                UNARY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (esc) begin
                        cnt <= CNT_W'(DATA_W - 1);
                    end
                end
                STOP: begin
                    if (k_reg != '0) begin
                        cnt <= CNT_W'(k_reg) - CNT_W'(1);
                        sh  <= x_reg << rem_sh;
                    end
                end
                REM, RAW: begin
                    sh <= sh << 1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rice_encoder.sv
// Self-checking bench for rice_encoder: table-driven codewords through a
// bit-level scoreboard, plus backpressure and mid-codeword reset sequences.
module tb_rice_encoder;

    localparam int DATA_W = 16;
    localparam int K_W    = 4;
    localparam int QMAX   = 24;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [K_W-1:0]    in_k = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_bit;
    logic              out_last;
    logic              busy;

    rice_encoder #(.DATA_W(DATA_W), .K_W(K_W), .QMAX(QMAX)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_k(in_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] x;
        logic [K_W-1:0]    k;
        int                mode;
        int                len;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference codeword built straight from the code definition.
    function automatic int push_model(input logic [DATA_W-1:0] x, input logic [K_W-1:0] k);
        int q;
        int n;
        q = int'(x >> k);
        n = 0;
        if (q >= QMAX) begin
            for (int i = 0; i < QMAX; i++) begin sb.push_back('{1'b1, 1'b0}); n++; end
            for (int i = DATA_W-1; i >= 0; i--) begin sb.push_back('{x[i], i == 0}); n++; end
        end else begin
            for (int i = 0; i < q; i++) begin sb.push_back('{1'b1, 1'b0}); n++; end
            sb.push_back('{1'b0, k == 0}); n++;
            for (int i = int'(k) - 1; i >= 0; i--) begin sb.push_back('{x[i], i == 0}); n++; end
        end
        return n;
    endfunction

    task automatic run_word(input logic [DATA_W-1:0] x, input logic [K_W-1:0] k,
                            input int mode, input int exp_len, input string tag);
        int   cyc, nbits, mlen;
        logic prev_v, prev_rdy, prev_bit, prev_last;
        bit   done;
        exp_t e;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, "_ready_before"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = x;
        in_k     = k;
        mlen = push_model(x, k);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        in_k     = K_W'($urandom);
        check({tag, "_first_valid"}, {out_valid, busy, in_ready}, 3'b110);
        nbits = 0; done = 0; cyc = 0;
        prev_v = 0; prev_rdy = 1; prev_bit = 0; prev_last = 0;
        while (!done && cyc < 400) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ((cyc % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_v && !prev_rdy)
                check({tag, "_hold"}, {out_valid, out_bit, out_last}, {1'b1, prev_bit, prev_last});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check({tag, "_extra_bit"}, nbits, mlen);
                    done = 1;
                end else begin
                    e = sb.pop_front();
                    check({tag, "_bit"}, {out_bit, out_last}, {e.b, e.last});
                    nbits++;
                    if (out_last) done = 1;
                end
            end
            prev_v = out_valid; prev_rdy = out_ready;
            prev_bit = out_bit; prev_last = out_last;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_len"}, nbits, exp_len);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_idle_after"}, {in_ready, busy, out_valid}, 3'b100);
        sb.delete();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        exp_t e;
        int   n, mlen;
        logic [DATA_W-1:0] rx;
        logic [K_W-1:0]    rk;

        vecs[0]  = '{16'd19,     4'd2,  0, 7};
        vecs[1]  = '{16'd5,      4'd0,  0, 6};
        vecs[2]  = '{16'd3,      4'd4,  0, 5};
        vecs[3]  = '{16'hFFFF,   4'd0,  0, 40};
        vecs[4]  = '{16'd23,     4'd0,  0, 24};
        vecs[5]  = '{16'd24,     4'd0,  0, 40};
        vecs[6]  = '{16'd19,     4'd2,  1, 7};
        vecs[7]  = '{16'd0,      4'd0,  0, 1};
        vecs[8]  = '{16'd0,      4'd15, 0, 16};
        vecs[9]  = '{16'hFFFF,   4'd15, 2, 17};
        vecs[10] = '{16'd47,     4'd1,  0, 25};
        vecs[11] = '{16'd48,     4'd1,  2, 40};
        vecs[12] = '{16'd100,    4'd3,  1, 16};

        #1;
        check("reset_outputs", {out_valid, out_bit, out_last, busy, in_ready}, 5'b0);
        repeat (3) @(negedge clk);
        check("reset_held", {out_valid, out_bit, out_last, busy, in_ready}, 5'b0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {in_ready, busy}, 2'b10);

        for (int i = 0; i < 13; i++)
            run_word(vecs[i].x, vecs[i].k, vecs[i].mode, vecs[i].len, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            rx = DATA_W'($urandom);
            rk = K_W'($urandom_range(4, 15));
            mlen = push_model(rx, rk);
            sb.delete();
            run_word(rx, rk, 2, mlen, $sformatf("rnd%0d", i));
        end

        // mid-codeword reset during the third bit of x=19,k=2
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1; in_data = 16'd19; in_k = 4'd2;
        mlen = push_model(16'd19, 4'd2);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                check("rst_pre_bit", {out_bit, out_last}, {e.b, e.last});
                n++;
            end
            @(negedge clk);
        end
        check("rst_pre_count", n, 2);
        check("rst_third_bit", {out_valid, out_bit, busy}, 3'b111);
        #2 reset = 1'b0;
        #1;
        check("rst_async", {out_valid, out_bit, out_last, busy, in_ready}, 5'b0);
        sb.delete();
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_held", {out_valid, busy, in_ready}, 3'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_ready", {in_ready, busy, out_valid}, 3'b100);
        run_word(16'd2, 4'd1, 0, 3, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rice_encoder.md
RICE_ENCODER -- requirements
Module: rice_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width.
REQ-002 SHALL have parameter K_W, default 4, meaning Rice parameter width (k = 0..15).
REQ-003 SHALL have parameter QMAX, default 24, meaning escape threshold on the quotient.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port in_valid  input  1  sample offered.
REQ-007 SHALL have port in_ready  output  1  encoder can accept a sample.
REQ-008 SHALL have port in_data  input  DATA_W  unsigned sample x.
REQ-009 SHALL have port in_k  input  K_W  Rice parameter k for this sample.
REQ-010 SHALL have port out_valid  output  1  out_bit is valid.
REQ-011 SHALL have port out_ready  input  1  downstream consumes out_bit.
REQ-012 SHALL have port out_bit  output  1  serial codeword bit, transmitted first to last.
REQ-013 SHALL have port out_last  output  1  out_bit is the final bit of the codeword.
REQ-014 SHALL have port busy  output  1  high while a codeword is in progress.

Function
REQ-015 SHALL accept a sample on the rising edge where in_valid && in_ready, latching in_data and in_k; in_ready SHALL be high only in IDLE.
REQ-016 SHALL compute q = x >> k and r = x mod 2^k from the latched values; q SHALL be held in a DATA_W-bit register with no truncation.
REQ-017 Normal code (q < QMAX) SHALL be q ones, one terminating zero, then the k bits of r, MSB first; length = q + 1 + k.
REQ-018 Escape code (q >= QMAX) SHALL be QMAX ones (no terminating zero), then all DATA_W bits of x, MSB first; length = QMAX + DATA_W.
REQ-019 SHALL implement an FSM with states IDLE, UNARY, STOP, REM, RAW.
REQ-020 Transitions: IDLE->UNARY on accept if q > 0; IDLE->STOP on accept if q = 0; UNARY->STOP after the q-th one when q < QMAX; UNARY->RAW after the QMAX-th one when q >= QMAX; STOP->REM if k > 0, else STOP->IDLE; REM->IDLE after r bit 0; RAW->IDLE after x bit 0.
REQ-021 The bit counter SHALL advance and the FSM SHALL transition only on the edge where out_valid && out_ready; with out_ready low, out_bit, out_last and state SHALL hold.
REQ-022 out_valid SHALL be high in every state except IDLE; the first codeword bit SHALL be valid in the cycle after the accept edge.
REQ-023 out_last SHALL be high exactly on the final bit: the STOP bit when k = 0, r bit 0 in REM, or x bit 0 in RAW.
REQ-024 SHALL insert one IDLE cycle between codewords.
REQ-025 The next accept SHALL occur no earlier than one cycle after the out_last handshake.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 Changes to in_data or in_k after acceptance SHALL not affect the codeword in progress.
REQ-028 q = QMAX - 1 SHALL use the normal code; q = QMAX SHALL use the escape code.

Reset
REQ-029 While reset = 0: state = IDLE, counters = 0, out_valid = 0, out_bit = 0, out_last = 0, busy = 0, in_ready = 0.
REQ-030 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-031 Reset mid-codeword SHALL discard the remaining bits immediately; no partial codeword SHALL resume.

Verification
REQ-032 x=19, k=2, out_ready=1 -> bits 1,1,1,1,0,1,1 on 7 consecutive cycles, out_last on the 7th bit, in_ready high again one cycle later.
REQ-033 x=5, k=0 -> bits 1,1,1,1,1,0; out_last on the 0; x=3, k=4 -> bits 0,0,0,1,1 (length 5).
REQ-034 x=0xFFFF, k=0 -> 24 ones then 16 ones (length 40, no zero); x=23<<0 (q=23) -> 23 ones then 0 (length 24).
REQ-035 x=19, k=2 with out_ready toggling 1,0,0,1,... -> same 7-bit sequence, each bit held stable while out_ready = 0, no bit lost or duplicated.
REQ-036 Assert reset=0 during the 3rd bit of x=19, k=2 -> outputs reach reset values asynchronously; after release, x=2, k=1 -> bits 1,0,0.
